adc_scan_sched: RTL and testbench
=================================

Name: adc_scan_sched

Overview:
Conversion scheduler that sits in front of adc_spi and shares it between a periodic multi-channel scan and one-shot conversion requests. Each scan period it steps through the enabled ADC128S channels. It drives adc_spi's channel/start_cnv, captures each 12-bit result into a per-channel shadow register, and lets effect logic read the latest pot/sample value for any channel at any time.

Parameters:
PERIOD, 2000, clocks between scan starts (scan timer terminal count + 1); legal range 16..65535.
CNT_W, 16, width of the scan timer.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable
ch_mask  in  8  bit i=1 -> channel i included in scan
req_vld  in  1  one-shot conversion request
req_ch  in  3  channel for one-shot request, sampled with req_vld
req_rdy  out  1  request accepted this cycle
req_done  out  1  one-cycle pulse, one-shot result valid on req_data
req_data  out  12  one-shot result, held until next req_done
start_cnv  out  1  to adc_spi, one-cycle pulse
channel  out  3  to adc_spi
cnv_complete  in  1  from adc_spi, one-cycle pulse
result  in  12  from adc_spi, valid with cnv_complete
rd_ch  in  3  shadow register select
rd_data  out  12  shadow[rd_ch], combinational read
rd_valid  out  1  shadow[rd_ch] written since reset
scan_done  out  1  one-cycle pulse at end of each scan
overrun  out  1  sticky; timer expired while previous scan still running
busy  out  1  high in START or CONV

Behaviour:
- Reset (async): state IDLE, timer 0, all shadows 0, valid bits 0, start_cnv/req_done/scan_done/req_rdy 0, channel 0, req_data 0, overrun 0, pending-scan flag 0.
- Timer: runs only while en=1. Counts 0..PERIOD-1 and wraps. Wrap cycle = tick. en=0 clears timer to 0 and pending flag; a conversion already in progress completes normally.
- tick sets pending-scan. The scan pointer loads 0 and the scan mask snapshot loads ch_mask. If a scan is already active at tick, overrun is set (sticky until reset), the pending flag is set, and the next scan begins right after the current scan_done.
- States: IDLE -> SELECT -> START -> CONV -> SELECT ... -> IDLE.
  - IDLE: go to SELECT when req_vld or pending-scan.
  - SELECT: one-shot request has priority over the next scan channel. If req_vld: req_rdy=1 this cycle, latch req_ch, go to START. Else pick the lowest set bit of the mask snapshot at index >= pointer and go to START. If no bit remains: scan_done pulse, clear pending, go to IDLE.
  - START: start_cnv=1 for exactly one cycle. channel is driven from SELECT onward and held stable until cnv_complete.
  - CONV: wait for cnv_complete. No timeout. On cnv_complete: scan -> shadow[channel]<=result, valid bit set, pointer<=channel+1; one-shot -> req_data<=result, req_done pulse same cycle, shadow is also updated. Go to SELECT.
- Start latency from scan start: tick at cycle T gives SELECT at T+1 and start_cnv at T+2, when idle and no request.
- A channel-7 conversion makes pointer 8. The next SELECT then ends the scan (no wrap within a scan).
- Empty ch_mask: the scan produces no conversions. scan_done pulses at T+2.
- req_vld must be held until req_rdy. Only one request is in flight at a time. Scan conversions are never aborted by requests.
- ch_mask changes mid-scan have no effect until the next tick.
- rd_data and rd_valid are combinational from the registers. A read of the channel being written in the same cycle returns the old value.
- cnv_complete outside CONV is ignored.

Test Plan:
- PERIOD=32, ch_mask=8'b0000_0101, en=1, stub ADC returns 12'h100+ch -> exactly two start_cnv per scan, channel 0 then 2, shadow[0]=12'h100, shadow[2]=12'h102, rd_valid 1 only for ch 0/2, one scan_done per 32 clocks.
- req_vld with req_ch=5 asserted mid-scan during ch 0 conversion, mask 0x07 -> ch 0 completes, then ch 5 converts (req_rdy at the following SELECT), req_done with req_data=12'h105, then ch 1, ch 2 resume.
- ch_mask=0 -> scan_done pulses 2 cycles after each tick, start_cnv never asserted, overrun stays 0.
- PERIOD=16 with ADC latency 20 clocks and mask 0xFF -> overrun set and remains 1. Scans run back-to-back with no idle cycle between scan_done and the next start_cnv.
- rst_n pulsed low mid-CONV (async, between clock edges) -> all outputs are immediately 0 and valid bits cleared. After release, the first start_cnv occurs at the first tick + 2.
- en dropped mid-scan -> the current conversion finishes and its shadow is written, no further start_cnv, timer holds 0. Re-enable -> the scan restarts from ch 0 after PERIOD clocks.

Source files
------------

// File: rtl/adc_scan_sched.sv
// adc_scan_sched: shares one adc_spi between a periodic multi-channel scan
// and one-shot conversion requests. Scan results land in per-channel shadow
// registers that can be read combinationally at any time.
module adc_scan_sched #(
    parameter int PERIOD = 2000,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  ch_mask,
    input  logic        req_vld,
    input  logic [2:0]  req_ch,
    output logic        req_rdy,
    output logic        req_done,
    output logic [11:0] req_data,
    output logic        start_cnv,
    output logic [2:0]  channel,
    input  logic        cnv_complete,
    input  logic [11:0] result,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        rd_valid,
    output logic        scan_done,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SELECT, START, CONV} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer;
    logic             tick;
    logic             pending;     // scan requested or in progress
    logic             rerun;       // tick arrived during a scan: rerun it when it ends
    logic [3:0]       ptr;         // next channel index to consider (8 = scan exhausted)
    logic [7:0]       scan_mask;   // ch_mask snapshot taken when the scan was armed
    logic             is_req;      // current conversion belongs to a one-shot request
    logic [11:0]      shadow [8];
    logic [7:0]       valid;

    logic             pick_found;
    logic [2:0]       pick_ch;
    logic             take_req, take_scan, scan_end, restart, conv_done;

    assign tick      = en && (timer == CNT_W'(PERIOD - 1));
    assign take_req  = (state == SELECT) && req_vld;
    assign take_scan = (state == SELECT) && !req_vld && pending && pick_found;
    assign scan_end  = (state == SELECT) && !req_vld && pending && !pick_found;
    assign restart   = scan_end && en && (rerun || tick);
    assign conv_done = (state == CONV) && cnv_complete;

    assign start_cnv = (state == START);
    assign busy      = (state == START) || (state == CONV);
    assign rd_data   = shadow[rd_ch];
    assign rd_valid  = valid[rd_ch];

    // Lowest enabled channel at or above the scan pointer
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (scan_mask[i] && (4'(i) >= ptr)) begin
                pick_found = 1'b1;
                pick_ch    = 3'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; requests win over the scan in SELECT, and an overrun
    // scan restarts straight from SELECT without passing through IDLE
    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        case (state)
            IDLE: begin
                if (req_vld || pending || tick) state_nxt = SELECT;
            end
            SELECT: begin
                if (req_vld) begin
                    req_rdy   = 1'b1;
                    state_nxt = START;
                end else if (pending && pick_found) begin
                    state_nxt = START;
                end else if (restart) begin
                    state_nxt = SELECT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START:   state_nxt = CONV;
            CONV:    if (cnv_complete) state_nxt = SELECT;
            default: state_nxt = IDLE;
        endcase
    end

    // Scan timer, pending/rerun flags, overrun, pointer and mask snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            pending   <= 1'b0;
            rerun     <= 1'b0;
            overrun   <= 1'b0;
            ptr       <= 4'd0;
            scan_mask <= 8'd0;
        end else begin
            if (!en) begin
                timer   <= '0;
                pending <= 1'b0;
                rerun   <= 1'b0;
            end else begin
                timer <= tick ? '0 : timer + CNT_W'(1);
                if (scan_end) begin
                    pending <= restart;
                    rerun   <= 1'b0;
                end else if (tick) begin
                    pending <= 1'b1;
                    if (pending) rerun <= 1'b1;
                end
                if (tick && pending) overrun <= 1'b1;
            end
            // a deferred scan reloads its pointer/mask only once the old one ends
            if (restart || (tick && !pending)) begin
                ptr       <= 4'd0;
                scan_mask <= ch_mask;
            end else if (conv_done && !is_req) begin
                ptr <= {1'b0, channel} + 4'd1;
            end
        end
    end

    // Channel latch at SELECT, held through START and CONV
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            channel <= 3'd0;
            is_req  <= 1'b0;
        end else if (take_req) begin
            channel <= req_ch;
            is_req  <= 1'b1;
        end else if (take_scan) begin
            channel <= pick_ch;
            is_req  <= 1'b0;
        end
    end

    // Result capture into shadows, one-shot result register and done pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) shadow[i] <= 12'd0;
            valid     <= 8'd0;
            req_data  <= 12'd0;
            req_done  <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            req_done  <= conv_done && is_req;
            scan_done <= scan_end;
            if (conv_done) begin
                shadow[channel] <= result;
                valid[channel]  <= 1'b1;
                if (is_req) req_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_sched.sv
// Testbench for adc_scan_sched: two instances (PERIOD 32 and PERIOD 16) each
// driven by a fixed-latency ADC stub returning 12'h100 + channel.
`timescale 1ns/10ps
module tb_adc_scan_sched;

    localparam int LAT_A = 4;    // clocks from start_cnv to cnv_complete
    localparam int LAT_B = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A (PERIOD=32)
    logic        en, req_vld, req_rdy, req_done, start_cnv, cnv_complete;
    logic        rd_valid, scan_done, overrun, busy;
    logic [7:0]  ch_mask;
    logic [2:0]  req_ch, channel, rd_ch;
    logic [11:0] req_data, result, rd_data;

    // instance B (PERIOD=16)
    logic        en_b, req_vld_b, req_rdy_b, req_done_b, start_cnv_b, cnv_complete_b;
    logic        rd_valid_b, scan_done_b, overrun_b, busy_b;
    logic [7:0]  ch_mask_b;
    logic [2:0]  req_ch_b, channel_b, rd_ch_b;
    logic [11:0] req_data_b, result_b, rd_data_b;

    adc_scan_sched #(.PERIOD(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
        .req_vld(req_vld), .req_ch(req_ch), .req_rdy(req_rdy),
        .req_done(req_done), .req_data(req_data),
        .start_cnv(start_cnv), .channel(channel),
        .cnv_complete(cnv_complete), .result(result),
        .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
        .scan_done(scan_done), .overrun(overrun), .busy(busy)
    );

    adc_scan_sched #(.PERIOD(16), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .ch_mask(ch_mask_b),
        .req_vld(req_vld_b), .req_ch(req_ch_b), .req_rdy(req_rdy_b),
        .req_done(req_done_b), .req_data(req_data_b),
        .start_cnv(start_cnv_b), .channel(channel_b),
        .cnv_complete(cnv_complete_b), .result(result_b),
        .rd_ch(rd_ch_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .scan_done(scan_done_b), .overrun(overrun_b), .busy(busy_b)
    );

    // ADC stub A
    int         cnt_a;
    logic [2:0] ch_a;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= 0; ch_a <= 3'd0; cnv_complete <= 1'b0; result <= 12'd0;
        end else begin
            cnv_complete <= 1'b0;
            if (cnt_a != 0) begin
                cnt_a <= cnt_a - 1;
                if (cnt_a == 1) begin cnv_complete <= 1'b1; result <= 12'h100 + 12'(ch_a); end
            end else if (start_cnv) begin
                cnt_a <= LAT_A - 1; ch_a <= channel;
            end
        end
    end

    // ADC stub B
    int         cnt_b;
    logic [2:0] ch_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_b <= 0; ch_b <= 3'd0; cnv_complete_b <= 1'b0; result_b <= 12'd0;
        end else begin
            cnv_complete_b <= 1'b0;
            if (cnt_b != 0) begin
                cnt_b <= cnt_b - 1;
                if (cnt_b == 1) begin cnv_complete_b <= 1'b1; result_b <= 12'h100 + 12'(ch_b); end
            end else if (start_cnv_b) begin
                cnt_b <= LAT_B - 1; ch_b <= channel_b;
            end
        end
    end

    // Event log sampled on the falling edge
    int          st_cyc[$], sd_cyc[$], st_cyc_b[$], sd_cyc_b[$];
    logic [2:0]  st_ch[$], st_ch_b[$];
    logic [11:0] rq_dat[$];
    always @(negedge clk) begin
        if (start_cnv)   begin st_cyc.push_back(cyc);   st_ch.push_back(channel);     end
        if (scan_done)   sd_cyc.push_back(cyc);
        if (req_done)    rq_dat.push_back(req_data);
        if (start_cnv_b) begin st_cyc_b.push_back(cyc); st_ch_b.push_back(channel_b); end
        if (scan_done_b) sd_cyc_b.push_back(cyc);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    function automatic int qsize(input int sel);
        case (sel)
            0:       return st_cyc.size();
            1:       return sd_cyc.size();
            2:       return st_cyc_b.size();
            default: return sd_cyc_b.size();
        endcase
    endfunction

    task automatic wait_q(input int sel, input int want, input int budget, input string name);
        int k = 0;
        while (qsize(sel) < want && k < budget) begin step(1); k++; end
        chk(name, qsize(sel), want);
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
        logic        vld;
    } rd_vec_t;
    rd_vec_t tbl[16];

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rd_ch = tbl[i].ch;
            #0.25;
            chk($sformatf("rd_data[%0d] vec%0d", tbl[i].ch, i), rd_data, tbl[i].data);
            chk($sformatf("rd_valid[%0d] vec%0d", tbl[i].ch, i), rd_valid, tbl[i].vld);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r0, r1, e0, f0, bs, bq, s, k;

        // shadows after scans with mask 0x05
        tbl[0]  = '{3'd0, 12'h100, 1'b1};
        tbl[1]  = '{3'd1, 12'h000, 1'b0};
        tbl[2]  = '{3'd2, 12'h102, 1'b1};
        tbl[3]  = '{3'd3, 12'h000, 1'b0};
        tbl[4]  = '{3'd4, 12'h000, 1'b0};
        tbl[5]  = '{3'd5, 12'h000, 1'b0};
        tbl[6]  = '{3'd6, 12'h000, 1'b0};
        tbl[7]  = '{3'd7, 12'h000, 1'b0};
        // after mask 0x07 scan with one-shot on channel 5
        tbl[8]  = '{3'd0, 12'h100, 1'b1};
        tbl[9]  = '{3'd1, 12'h101, 1'b1};
        tbl[10] = '{3'd2, 12'h102, 1'b1};
        tbl[11] = '{3'd3, 12'h000, 1'b0};
        tbl[12] = '{3'd4, 12'h000, 1'b0};
        tbl[13] = '{3'd5, 12'h105, 1'b1};
        tbl[14] = '{3'd6, 12'h000, 1'b0};
        tbl[15] = '{3'd7, 12'h000, 1'b0};

        rst_n = 1'b0; en = 1'b1; ch_mask = 8'h05; req_vld = 1'b0; req_ch = 3'd0; rd_ch = 3'd0;
        en_b = 1'b0; ch_mask_b = 8'hFF; req_vld_b = 1'b0; req_ch_b = 3'd0; rd_ch_b = 3'd0;
        step(1);

        // reset state
        chk("reset start_cnv", start_cnv, 0);
        chk("reset busy", busy, 0);
        chk("reset channel", channel, 0);
        chk("reset req_rdy", req_rdy, 0);
        chk("reset req_done", req_done, 0);
        chk("reset req_data", req_data, 0);
        chk("reset scan_done", scan_done, 0);
        chk("reset overrun", overrun, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);

        // periodic scan, mask 0x05
        rst_n = 1'b1;
        r0 = cyc;
        wait_q(1, 2, 150, "scan_done count two scans");
        chk("starts in two scans", st_cyc.size(), 4);
        chk("first start latency", st_cyc[0], r0 + 33);
        chk("scan start0 ch", st_ch[0], 0);
        chk("scan start1 ch", st_ch[1], 2);
        chk("scan start2 ch", st_ch[2], 0);
        chk("scan start3 ch", st_ch[3], 2);
        chk("second start cycle", st_cyc[1], r0 + 39);
        chk("first scan_done cycle", sd_cyc[0], r0 + 45);
        chk("scan_done spacing", sd_cyc[1] - sd_cyc[0], 32);
        run_tbl(0, 8);

        // one-shot request during channel 0 conversion, mask 0x07
        ch_mask = 8'h07;
        bs = st_cyc.size();
        bq = rq_dat.size();
        wait_q(0, bs + 1, 60, "ch0 start before request");
        s = st_cyc[bs];
        chk("pre-request ch", st_ch[bs], 0);
        step(1);
        req_vld = 1'b1; req_ch = 3'd5;
        k = 0;
        while (!req_rdy && k < 20) begin step(1); k++; end
        chk("req_rdy cycle", cyc, s + 5);
        step(1);
        req_vld = 1'b0;
        wait_q(1, 3, 80, "scan_done after request");
        chk("starts in request scan", st_cyc.size(), bs + 4);
        chk("request ch", st_ch[bs + 1], 5);
        chk("request start cycle", st_cyc[bs + 1] - s, 6);
        chk("resume ch1", st_ch[bs + 2], 1);
        chk("resume ch2", st_ch[bs + 3], 2);
        chk("req_done count", rq_dat.size(), bq + 1);
        chk("req_done data", rq_dat[bq], 12'h105);
        chk("req_data held", req_data, 12'h105);
        run_tbl(8, 16);

        // empty mask
        ch_mask = 8'h00;
        bs = st_cyc.size();
        wait_q(1, 5, 80, "empty-mask scan_done count");
        chk("empty scan_done 1", sd_cyc[3], r0 + 129);
        chk("empty scan_done 2", sd_cyc[4], r0 + 161);
        chk("empty no start_cnv", st_cyc.size(), bs);
        chk("empty overrun", overrun, 0);

        // asynchronous reset mid-conversion
        ch_mask = 8'h05;
        bs = st_cyc.size();
        wait_q(0, bs + 1, 60, "start before reset");
        chk("pre-reset start cycle", st_cyc[bs], r0 + 193);
        step(1);
        rd_ch = 3'd0;
        #0.25;
        chk("pre-reset busy", busy, 1);
        chk("pre-reset rd_valid", rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", busy, 0);
        chk("async start_cnv", start_cnv, 0);
        chk("async channel", channel, 0);
        chk("async req_data", req_data, 0);
        chk("async rd_valid", rd_valid, 0);
        chk("async rd_data", rd_data, 0);
        chk("async overrun", overrun, 0);
        step(3);
        rst_n = 1'b1;
        r1 = cyc;
        bs = st_cyc.size();
        wait_q(0, bs + 1, 60, "start after reset");
        chk("post-reset start cycle", st_cyc[bs], r1 + 33);
        chk("post-reset start ch", st_ch[bs], 0);

        // en dropped during the channel 0 conversion
        step(1);
        en = 1'b0;
        step(60);
        chk("no start while disabled", st_cyc.size(), bs + 1);
        rd_ch = 3'd0;
        #0.25;
        chk("disabled ch0 rd_valid", rd_valid, 1);
        chk("disabled ch0 rd_data", rd_data, 12'h100);
        rd_ch = 3'd2;
        #0.25;
        chk("disabled ch2 rd_valid", rd_valid, 0);
        step(1);
        en = 1'b1;
        e0 = cyc;
        wait_q(0, bs + 2, 60, "start after re-enable");
        chk("re-enable start cycle", st_cyc[bs + 1], e0 + 33);
        chk("re-enable start ch", st_ch[bs + 1], 0);

        // overrun: PERIOD 16, ADC latency 20, mask 0xFF
        en_b = 1'b1;
        f0 = cyc;
        chk("B overrun before", overrun_b, 0);
        wait_q(3, 1, 300, "B first scan_done");
        chk("B overrun after first scan", overrun_b, 1);
        wait_q(3, 2, 300, "B second scan_done");
        chk("B first start cycle", st_cyc_b[0], f0 + 17);
        chk("B channel spacing", st_cyc_b[1] - st_cyc_b[0], 22);
        for (int i = 0; i < 8; i++) chk($sformatf("B scan ch%0d", i), st_ch_b[i], i);
        chk("B first scan_done cycle", sd_cyc_b[0], f0 + 193);
        chk("B back-to-back start", st_cyc_b[8], sd_cyc_b[0] + 1);
        chk("B restart ch", st_ch_b[8], 0);
        chk("B scan_done spacing", sd_cyc_b[1] - sd_cyc_b[0], 177);
        chk("B overrun sticky", overrun_b, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
